// File: rtl/ibex_bcp_check_seq_pkg.sv
// rtl/ibex_bcp_check_seq_pkg.sv - BCP region types, access encodings and helpers
package ibex_bcp_check_seq_pkg;

  localparam int unsigned BCPNumRegionsDefault = 4;

  typedef struct packed {
    logic lock;
    logic s;
    logic a;
    logic l;
    logic en;
  } bcp_cfg_t;

  typedef struct packed {
    logic enforce;
  } bcp_mseccfg_t;

  typedef enum logic [1:0] {
    BCP_LOAD  = 2'd0,
    BCP_ARITH = 2'd1,
    BCP_STORE = 2'd2
  } bcp_acc_e;

  localparam logic [1:0] BCP_ACC_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    BCP_SEQ_IDLE = 2'd0,
    BCP_SEQ_SCAN = 2'd1,
    BCP_SEQ_RESP = 2'd2
  } bcp_seq_state_e;

  // Permission bit of a region for the given access type; the illegal type has none.
  function automatic logic bcp_type_allowed(bcp_cfg_t cfg, logic [1:0] acc_type);
    logic allowed;
    case (acc_type)
      BCP_LOAD:  allowed = cfg.l;
      BCP_ARITH: allowed = cfg.a;
      BCP_STORE: allowed = cfg.s;
      default:   allowed = 1'b0;
    endcase
    return allowed;
  endfunction

  // Address of the last byte touched; size 2 is widened to a full word.
  function automatic logic [32:0] bcp_access_end(logic [31:0] addr, logic [1:0] size);
    logic [1:0] sz;
    sz = (size == 2'd2) ? 2'd3 : size;
    return {1'b0, addr} + {31'b0, sz};
  endfunction

endpackage

// File: rtl/ibex_bcp_check_seq_if.sv
// rtl/ibex_bcp_check_seq_if.sv - ID-stage request/response bundle of the BCP check sequencer
interface ibex_bcp_check_seq_if;

  logic        req_i;
  logic        ready_o;
  logic [1:0]  req_type_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic        kill_i;
  logic        valid_o;
  logic        err_o;
  logic        load_err_o;
  logic        arith_err_o;
  logic        store_err_o;
  logic        busy_o;

  modport master (
    output req_i, req_type_i, req_addr_i, req_size_i, kill_i,
    input  ready_o, valid_o, err_o, load_err_o, arith_err_o, store_err_o, busy_o
  );

  modport slave (
    input  req_i, req_type_i, req_addr_i, req_size_i, kill_i,
    output ready_o, valid_o, err_o, load_err_o, arith_err_o, store_err_o, busy_o
  );

endinterface

// File: rtl/ibex_bcp_check_seq_region_match.sv
// rtl/ibex_bcp_check_seq_region_match.sv - single shared BCP region comparator
module ibex_bcp_region_match
  import ibex_bcp_check_seq_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [32:0] acc_end,
  input  logic [31:0] base,
  input  logic [31:0] limit,
  input  bcp_cfg_t    cfg,
  input  logic [1:0]  acc_type,
  output logic        hit
);

  logic in_range;
  logic unused_lock;

  assign unused_lock = cfg.lock;

  // The end is compared at 33 bits, so an access wrapping past 2^32 can never fit.
  assign in_range = (base < limit) & (base <= addr) & (acc_end < {1'b0, limit});

  assign hit = cfg.en & bcp_type_allowed(cfg, acc_type) & in_range;

endmodule

// File: rtl/ibex_bcp_check_seq.sv
// rtl/ibex_bcp_check_seq.sv - serial BCP bound-check sequencer, one region per cycle
module ibex_bcp_check_seq
  import ibex_bcp_check_seq_pkg::*;
#(
  parameter int unsigned BCPNumRegions = BCPNumRegionsDefault
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  ibex_bcp_check_seq_if.slave                 bus,
  input  logic     [BCPNumRegions-1:0][31:0]  csr_bcp_base_i,
  input  logic     [BCPNumRegions-1:0][31:0]  csr_bcp_limit_i,
  input  bcp_cfg_t [BCPNumRegions-1:0]        csr_bcp_cfg_i,
  input  bcp_mseccfg_t                        csr_bcp_mseccfg_i
);

  localparam int unsigned IdxW = (BCPNumRegions > 1) ? $clog2(BCPNumRegions) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BCPNumRegions - 1);

  localparam logic [1:0] ST_IDLE = BCP_SEQ_IDLE;
  localparam logic [1:0] ST_SCAN = BCP_SEQ_SCAN;
  localparam logic [1:0] ST_RESP = BCP_SEQ_RESP;

  logic [1:0]      state_q;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     addr_q;
  logic [32:0]     end_q;
  logic [1:0]      type_q;
  logic            err_q;

  logic            accept;
  logic            hit;

  // RESP accepts too, so back-to-back checks lose no cycle.
  assign bus.ready_o = ((state_q == ST_IDLE) | (state_q == ST_RESP)) & ~bus.kill_i;
  assign accept      = bus.req_i & bus.ready_o;

  ibex_bcp_region_match u_region_match (
    .addr     (addr_q),
    .acc_end  (end_q),
    .base     (csr_bcp_base_i[idx_q]),
    .limit    (csr_bcp_limit_i[idx_q]),
    .cfg      (csr_bcp_cfg_i[idx_q]),
    .acc_type (type_q),
    .hit      (hit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      end_q   <= '0;
      type_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            addr_q <= bus.req_addr_i;
            end_q  <= bcp_access_end(bus.req_addr_i, bus.req_size_i);
            type_q <= bus.req_type_i;
            idx_q  <= '0;
            if (!csr_bcp_mseccfg_i.enforce) begin
              state_q <= ST_RESP;
              err_q   <= 1'b0;
            end else if (bus.req_type_i == BCP_ACC_ILLEGAL) begin
              state_q <= ST_RESP;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_SCAN;
              err_q   <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          // Lowest index wins: the first hit ends the scan.
          if (bus.kill_i) begin
            state_q <= ST_IDLE;
          end else if (hit) begin
            state_q <= ST_RESP;
            err_q   <= 1'b0;
          end else if (idx_q == LastIdx) begin
            state_q <= ST_RESP;
            err_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.valid_o     = (state_q == ST_RESP) & ~bus.kill_i;
  assign bus.err_o       = bus.valid_o & err_q;
  assign bus.load_err_o  = bus.err_o & (type_q == BCP_LOAD);
  assign bus.arith_err_o = bus.err_o & (type_q == BCP_ARITH);
  assign bus.store_err_o = bus.err_o & (type_q == BCP_STORE);
  assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ibex_bcp_check_seq.sv
// tb/tb_ibex_bcp_check_seq.sv - scoreboard bench for the BCP check sequencer
module tb_ibex_bcp_check_seq;
  import ibex_bcp_check_seq_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ibex_bcp_check_seq_if bus();

  logic     [N-1:0][31:0] base;
  logic     [N-1:0][31:0] limit;
  bcp_cfg_t [N-1:0]       cfg;
  bcp_mseccfg_t           msec;

  ibex_bcp_check_seq #(.BCPNumRegions(N)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .bus               (bus),
    .csr_bcp_base_i    (base),
    .csr_bcp_limit_i   (limit),
    .csr_bcp_cfg_i     (cfg),
    .csr_bcp_mseccfg_i (msec)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit err;
    bit le;
    bit ae;
    bit se;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the access covers bytes [a, a+nb); it passes if it fits wholly in the
  // first enabled, permitted region [base, limit), scanning lowest index first.
  function automatic void model(input logic [1:0] t, input logic [31:0] a, input logic [1:0] sz,
                                output bit err, output int lat);
    logic [63:0] last;
    int nb;
    bit allowed;
    nb   = (sz == 2'd2) ? 4 : int'(sz) + 1;
    last = {32'b0, a} + 64'(nb - 1);
    err  = 1'b1;
    lat  = N + 1;
    if (!msec.enforce) begin
      err = 1'b0;
      lat = 1;
    end else if (t == 2'd3) begin
      lat = 1;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        allowed = (t == 2'd0) ? cfg[i].l : (t == 2'd1) ? cfg[i].a : cfg[i].s;
        if (cfg[i].en && allowed && ({32'b0, base[i]} <= {32'b0, a}) && (last < {32'b0, limit[i]})) begin
          err = 1'b0;
          lat = i + 2;
        end
      end
    end
  endfunction

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [1:0] sz,
                       input bit expect_resp, output int lat);
    bit ok;
    bit err;
    exp_t e;
    ok  = 1'b0;
    lat = 1;
    bus.req_i      = 1'b1;
    bus.req_type_i = t;
    bus.req_addr_i = a;
    bus.req_size_i = sz;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        ok = 1'b1;
        model(t, a, sz, err, lat);
        if (expect_resp) begin
          e.cyc = cyc + lat;
          e.err = err;
          e.le  = err && (t == 2'd0);
          e.ae  = err && (t == 2'd1);
          e.se  = err && (t == 2'd2);
          sbq.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    bus.req_i = 1'b0;
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [1:0] t, input logic [31:0] a, input logic [1:0] sz);
    int lat;
    issue(t, a, sz, 1'b1, lat);
    cycles(lat);
  endtask

  task automatic set_region(input int i, input logic [31:0] b, input logic [31:0] l,
                            input bit en, input bit lr, input bit ar, input bit sr);
    cfg[i]   = '{lock: 1'b0, s: sr, a: ar, l: lr, en: en};
    base[i]  = b;
    limit[i] = l;
  endtask

  task automatic clear_csr();
    for (int i = 0; i < N; i++) set_region(i, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_csr();
    logic [31:0] b;
    logic [31:0] l;
    msec.enforce = ($urandom_range(0, 7) != 0);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = 32'hFFFF_FF00 + 32'($urandom_range(0, 'h80));
        l = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      end else begin
        b = 32'($urandom_range(0, 'h300));
        l = 32'($urandom_range(0, 'h400));
      end
      set_region(i, b, l, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
    return 32'($urandom_range(0, 'h400));
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_o) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 64'(1), 64'(0));
        end else begin
          mon_e = sbq.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("err_o", 64'(bus.err_o), 64'(mon_e.err));
          chk("typed_err", 64'({bus.load_err_o, bus.arith_err_o, bus.store_err_o}),
              64'({mon_e.le, mon_e.ae, mon_e.se}));
        end
      end else begin
        chk("flags_without_valid",
            64'({bus.err_o, bus.load_err_o, bus.arith_err_o, bus.store_err_o}), 64'(0));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int lat2;
    int mode;
    int j;
    logic [1:0] t;
    logic [1:0] sz;
    logic [31:0] a;

    rst = 1'b1;
    bus.req_i = 1'b0;
    bus.kill_i = 1'b0;
    bus.req_type_i = 2'd0;
    bus.req_addr_i = 32'h0;
    bus.req_size_i = 2'd0;
    clear_csr();
    msec.enforce = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(bus.busy_o), 64'(0));
    chk("reset_valid", 64'(bus.valid_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 64'(bus.ready_o), 64'(1));
    chk("post_reset_busy", 64'(bus.busy_o), 64'(0));
    @(posedge clk); #1;

    set_region(0, 32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
    run(2'd0, 32'h1FFC, 2'd3);
    run(2'd0, 32'h1FFE, 2'd3);
    run(2'd0, 32'h1FFD, 2'd2);

    clear_csr();
    set_region(2, 32'h0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
    run(2'd2, 32'h10, 2'd0);
    run(2'd1, 32'h10, 2'd0);

    msec.enforce = 1'b0;
    run(2'd2, 32'hDEAD_0000, 2'd3);
    msec.enforce = 1'b1;
    run(2'd3, 32'h10, 2'd0);

    clear_csr();
    set_region(0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run(2'd0, 32'hFFFF_FFFE, 2'd3);
    run(2'd0, 32'hFFFF_FFF0, 2'd3);

    clear_csr();
    set_region(0, 32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(2'd0, 32'h1FFE, 2'd3, 1'b0, lat);
    bus.kill_i = 1'b1;
    @(posedge clk); #1;
    bus.kill_i = 1'b0;
    @(negedge clk);
    chk("kill_busy", 64'(bus.busy_o), 64'(0));
    @(posedge clk); #1;

    issue(2'd0, 32'h1FFC, 2'd3, 1'b1, lat);
    cycles(lat - 1);
    issue(2'd0, 32'h1FFE, 2'd3, 1'b1, lat2);
    cycles(lat2 - 1);
    run(2'd1, 32'h1000, 2'd0);

    bus.req_i = 1'b1;
    bus.kill_i = 1'b1;
    @(negedge clk);
    chk("kill_blocks_ready", 64'(bus.ready_o), 64'(0));
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    bus.kill_i = 1'b0;
    @(negedge clk);
    chk("kill_wins_busy", 64'(bus.busy_o), 64'(0));
    @(posedge clk); #1;

    issue(2'd0, 32'h3000, 2'd0, 1'b1, lat);
    @(negedge clk);
    chk("ready_in_scan", 64'(bus.ready_o), 64'(0));
    @(posedge clk); #1;
    cycles(lat - 1);

    issue(2'd0, 32'h3000, 2'd0, 1'b0, lat);
    cycles(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midscan_reset_busy", 64'(bus.busy_o), 64'(0));
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) rand_csr();
      t    = 2'($urandom_range(0, 3));
      sz   = 2'($urandom_range(0, 3));
      a    = pick_addr();
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        issue(t, a, sz, 1'b0, lat);
        j = $urandom_range(1, lat);
        cycles(j - 1);
        bus.kill_i = 1'b1;
        @(posedge clk); #1;
        bus.kill_i = 1'b0;
        @(negedge clk);
        chk("rand_kill_busy", 64'(bus.busy_o), 64'(0));
        @(posedge clk); #1;
      end else if (mode <= 3) begin
        issue(t, a, sz, 1'b1, lat);
        cycles(lat - 1);
      end else begin
        issue(t, a, sz, 1'b1, lat);
        cycles(lat - 1 + $urandom_range(1, 3));
      end
    end

    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
    cycles(2);
    chk("pending_responses", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_bcp_check_seq.md
Name: ibex_bcp_check_seq

Overview:
- Sequencer for the bound-checking (BCP) resource of the execution stage.
- Accepts one address check per request (load, arith or store) and scans the BCP regions using one shared region comparator, one region per cycle.
- Returns a single pass/fail response with type-specific error flags to the ID stage.
- Replaces the tied-off BCP error outputs of the EX block, trading latency for area.

Parameters:
- BCPNumRegions, 4, number of regions scanned (1..16).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  check request.
- ready_o  out  1  request accepted when req_i & ready_o.
- req_type_i  in  2  bcp_acc_e: 0 load, 1 arith, 2 store, 3 illegal.
- req_addr_i  in  32  access start address.
- req_size_i  in  2  access bytes minus one: 0, 1 or 3; value 2 is treated as 3.
- kill_i  in  1  flush from ID; aborts any in-flight check.
- csr_bcp_base_i  in  32 x BCPNumRegions  region base (inclusive).
- csr_bcp_limit_i  in  32 x BCPNumRegions  region limit (exclusive).
- csr_bcp_cfg_i  in  bcp_cfg_t x BCPNumRegions  per-region {en, l, a, s, lock}.
- csr_bcp_mseccfg_i  in  bcp_mseccfg_t  {enforce}.
- valid_o  out  1  response valid, one-cycle pulse.
- err_o  out  1  check failed; qualified by valid_o.
- load_err_o, arith_err_o, store_err_o  out  1 each  typed error, pulsed with valid_o.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - state=IDLE, idx=0, err register=0.
  - valid_o, err_o, all typed errors and busy_o = 0; ready_o = 1 from the first cycle after reset.
- States: IDLE, SCAN, RESP.
- ready_o = (state==IDLE | state==RESP) & ~kill_i.
- Accept (req_i & ready_o):
  - Latch addr, type and size; set end = addr + size (33-bit).
  - Set idx=0.
  - Next state:
    - enforce=0 → RESP with err=0.
    - type==3 → RESP with err=1.
    - otherwise → SCAN.
- SCAN, evaluated each cycle on region idx:
  - Hit condition: en & type-bit (l/a/s) & base <= addr & end < limit, with end compared at 33 bits.
  - A carry into bit 32 of end never hits.
  - limit <= base makes the region empty.
  - hit → RESP with err=0.
  - miss & idx==BCPNumRegions-1 → RESP with err=1.
  - otherwise idx++.
- RESP:
  - valid_o = ~kill_i; err_o = err.
  - Typed error = err & (latched type matches); all typed errors are 0 for type 3.
  - Next state is IDLE, or SCAN/RESP if a new request is accepted in the same cycle (back-to-back).
- Latency from accept to valid_o:
  - 1 cycle for enforce=0 or illegal type.
  - k+2 cycles when region k hits.
  - BCPNumRegions+1 cycles on full miss.
- Kill handling:
  - kill_i in SCAN or RESP → IDLE next cycle, no valid_o.
  - kill_i in IDLE blocks acceptance (ready_o=0).
  - kill_i and req_i in the same cycle: kill wins, request not accepted.
- CSR timing: CSR inputs are read live each SCAN cycle. CSR writes during a scan are legal and affect only regions not yet evaluated; the ID stage flushes (kill_i) after BCP CSR writes.
- rst_i mid-scan: immediate IDLE, no response.
- Region priority: lowest index first; the first hit terminates the scan.

Decomposition:
- Additions to ibex_pkg:
  - BCPNumRegions default constant.
  - bcp_cfg_t packed {lock, s, a, l, en}.
  - bcp_mseccfg_t {enforce}.
  - bcp_acc_e {BCP_LOAD, BCP_ARITH, BCP_STORE}.
  - bcp_seq_state_e.
- Sub-module ibex_bcp_region_match: combinational; inputs addr, end[32:0], base, limit, cfg, type; output hit. A single instance is muxed by idx.

Test Plan:
- enforce=1; region0 {en,l} base=0x1000 limit=0x2000; load addr=0x1FFC size=3 → valid_o at accept+2, err_o=0.
- Same region; load addr=0x1FFE size=3 (end 0x2001) → miss all 4 regions; valid_o at accept+5, err_o=1, load_err_o=1, arith_err_o=store_err_o=0.
- Region2 {en,s} base=0x0 limit=0x100; region0/1 disabled; store addr=0x10 size=0 → valid_o at accept+4, err_o=0; same access as arith → err_o=1, arith_err_o=1.
- enforce=0; any store → valid_o at accept+1, err_o=0. Separately, type=3 with enforce=1 → valid_o at accept+1, err_o=1, all typed errors 0.
- Region base=0xFFFFFFF0 limit=0xFFFFFFFF (en,l); load addr=0xFFFFFFFE size=3 (carry into bit 32) → err_o=1.
- kill_i asserted 1 cycle after accept → no valid_o, busy_o=0 next cycle. Then back-to-back requests issued in the RESP cycle → second accepted, both responses correct and in order.
